spmv_line_fetcher: RTL and testbench



---
 rtl/spmv_pkg.sv | 9 +
 rtl/spmv_tag_rob.sv | 63 ++++++
 rtl/spmv_line_fetcher.sv | 129 ++++++++++++
 tb/tb_spmv_line_fetcher.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV line-fetch path: line geometry and the
// slot / fetcher state encodings.
package spmv_pkg;
    localparam int SPMV_LINE_BYTES = 64;
    localparam int SPMV_LINE_OFS   = 6;

    typedef enum logic [1:0] {SLOT_FREE, SLOT_PEND, SLOT_FULL} slot_state_t;
    typedef enum logic {FETCH_IDLE, FETCH_RUN} fetch_state_t;
endpackage

// File: rtl/spmv_tag_rob.sv
// Reorder buffer for in-flight cache lines: one slot per transid, with a
// per-slot FREE/PEND/FULL state and a registered line payload.
module spmv_tag_rob #(
    parameter int NUM_TAGS = 8,
    parameter int TID_BASE = 0,
    parameter int LINE_W   = 512,
    localparam int TAG_W   = $clog2(NUM_TAGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_i,
    input  logic [TAG_W-1:0]  alloc_slot_i,
    input  logic              fill_val_i,
    input  logic [5:0]        fill_tid_i,
    input  logic [LINE_W-1:0] fill_data_i,
    input  logic              pop_i,
    input  logic [TAG_W-1:0]  head_i,
    input  logic [TAG_W-1:0]  issue_slot_i,
    output logic              head_full_o,
    output logic [LINE_W-1:0] head_data_o,
    output logic              slot_free_o,
    output logic              stray_o
);
    import spmv_pkg::*;

    slot_state_t       state_q [NUM_TAGS];
    slot_state_t       state_d [NUM_TAGS];
    logic [LINE_W-1:0] data_q  [NUM_TAGS];

    // 7-bit offset so ids below TID_BASE wrap far above NUM_TAGS.
    logic [6:0]       tid_ofs;
    logic [TAG_W-1:0] fill_slot;
    logic             fill_ok;

    assign tid_ofs   = {1'b0, fill_tid_i} - 7'(TID_BASE);
    assign fill_slot = tid_ofs[TAG_W-1:0];
    assign fill_ok   = fill_val_i && (tid_ofs < 7'(NUM_TAGS)) && (state_q[fill_slot] == SLOT_PEND);
    assign stray_o   = fill_val_i && !fill_ok;

    // alloc hits a FREE slot, fill a PEND slot, pop a FULL slot: never the same one.
    always_comb begin
        state_d = state_q;
        if (alloc_i) state_d[alloc_slot_i] = SLOT_PEND;
        if (fill_ok) state_d[fill_slot]    = SLOT_FULL;
        if (pop_i)   state_d[head_i]       = SLOT_FREE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++) state_q[i] <= SLOT_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_ok) data_q[fill_slot] <= fill_data_i;
    end

    assign head_full_o = (state_q[head_i] == SLOT_FULL);
    assign head_data_o = data_q[head_i];
    assign slot_free_o = (state_q[issue_slot_i] == SLOT_FREE);
endmodule

// File: rtl/spmv_line_fetcher.sv
// Streams a run of 64-byte lines from L2: tags up to NUM_TAGS requests,
// reorders responses and delivers lines in address order.
module spmv_line_fetcher #(
    parameter int NUM_TAGS = 8,
    parameter int TID_BASE = 0,
    parameter int PADDR_W  = 40,
    parameter int LINE_W   = 512,
    parameter int LEN_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    input  logic [PADDR_W-1:0] cmd_base_addr,
    input  logic [LEN_W-1:0]   cmd_num_lines,
    output logic               mem_req_val,
    input  logic               mem_req_rdy,
    output logic [5:0]         mem_req_transid,
    output logic [PADDR_W-1:0] mem_req_addr,
    input  logic               mem_resp_val,
    input  logic [5:0]         mem_resp_transid,
    input  logic [LINE_W-1:0]  mem_resp_data,
    output logic               line_val,
    input  logic               line_rdy,
    output logic [LINE_W-1:0]  line_data,
    output logic               line_last,
    output logic               busy,
    output logic               err_stray
);
    import spmv_pkg::*;

    localparam int TAG_W = $clog2(NUM_TAGS);

    fetch_state_t       state_q, state_d;
    logic [PADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]   num_q, num_d;
    logic [LEN_W-1:0]   issue_q, issue_d;
    logic [LEN_W-1:0]   pop_q, pop_d;
    logic               err_q, err_d;

    logic               run, slot_free, head_full, stray;
    logic               req_val, req_fire, pop_fire;
    logic [LINE_W-1:0]  head_data;
    logic [TAG_W-1:0]   issue_slot, head_slot;

    assign run        = (state_q == FETCH_RUN);
    assign issue_slot = issue_q[TAG_W-1:0];
    assign head_slot  = pop_q[TAG_W-1:0];

    assign req_val  = run && (issue_q < num_q) && slot_free;
    assign req_fire = req_val && mem_req_rdy;
    assign line_val = run && head_full;
    assign pop_fire = line_val && line_rdy;

    // Address and transid are gated so idle outputs read as zero.
    assign mem_req_val     = req_val;
    assign mem_req_addr    = req_val ? base_q + (PADDR_W'(issue_q) << SPMV_LINE_OFS) : '0;
    assign mem_req_transid = req_val ? 6'(TID_BASE) + 6'(issue_slot) : '0;
    assign line_data       = line_val ? head_data : '0;
    assign line_last       = line_val && (pop_q == num_q - LEN_W'(1));
    assign cmd_rdy         = (state_q == FETCH_IDLE);
    assign busy            = run;
    assign err_stray       = err_q;

    spmv_tag_rob #(
        .NUM_TAGS (NUM_TAGS),
        .TID_BASE (TID_BASE),
        .LINE_W   (LINE_W)
    ) u_rob (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (req_fire),
        .alloc_slot_i (issue_slot),
        .fill_val_i   (mem_resp_val),
        .fill_tid_i   (mem_resp_transid),
        .fill_data_i  (mem_resp_data),
        .pop_i        (pop_fire),
        .head_i       (head_slot),
        .issue_slot_i (issue_slot),
        .head_full_o  (head_full),
        .head_data_o  (head_data),
        .slot_free_o  (slot_free),
        .stray_o      (stray)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        issue_d = issue_q;
        pop_d   = pop_q;
        err_d   = err_q | stray;
        unique case (state_q)
            FETCH_IDLE: begin
                if (cmd_val) begin
                    base_d  = cmd_base_addr & ~PADDR_W'(SPMV_LINE_BYTES - 1);
                    num_d   = cmd_num_lines;
                    issue_d = '0;
                    pop_d   = '0;
                    if (cmd_num_lines != '0) state_d = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                if (req_fire) issue_d = issue_q + LEN_W'(1);
                if (pop_fire) pop_d = pop_q + LEN_W'(1);
                if (pop_fire && line_last) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            issue_q <= '0;
            pop_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            issue_q <= issue_d;
            pop_q   <= pop_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_spmv_line_fetcher.sv
// Scoreboard bench for spmv_line_fetcher: a memory model answers requests in
// several orders, monitors compare requests and lines against expected queues.
module tb_spmv_line_fetcher;
    localparam int NT   = 8;
    localparam int TBS  = 0;
    localparam int PW   = 40;
    localparam int LW   = 512;
    localparam int LENW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_val, cmd_rdy;
    logic [PW-1:0]   cmd_base_addr;
    logic [LENW-1:0] cmd_num_lines;
    logic            mem_req_val, mem_req_rdy;
    logic [5:0]      mem_req_transid;
    logic [PW-1:0]   mem_req_addr;
    logic            mem_resp_val;
    logic [5:0]      mem_resp_transid;
    logic [LW-1:0]   mem_resp_data;
    logic            line_val, line_rdy, line_last, busy, err_stray;
    logic [LW-1:0]   line_data;

    spmv_line_fetcher #(.NUM_TAGS(NT), .TID_BASE(TBS), .PADDR_W(PW), .LINE_W(LW), .LEN_W(LENW)) dut (
        .clk(clk), .rst(rst), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .cmd_base_addr(cmd_base_addr), .cmd_num_lines(cmd_num_lines),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
        .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
        .mem_resp_data(mem_resp_data), .line_val(line_val), .line_rdy(line_rdy),
        .line_data(line_data), .line_last(line_last), .busy(busy), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {logic [5:0] tid; logic [PW-1:0] addr;} req_t;
    typedef struct {logic [LW-1:0] data; logic last;} line_t;
    typedef struct {logic [5:0] tid; logic [PW-1:0] addr; int cyc;} pend_t;

    req_t  exp_req[$];
    line_t exp_line[$];
    pend_t pending[$];
    int    nreq = 0;

    // Memory contents: every line carries its own address.
    function automatic logic [LW-1:0] line_of(logic [PW-1:0] a);
        return {8{{24'h5A5A5A, a}}};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready drivers: 0 low, 1 high, 2 toggle, 3 random.
    int lrdy_mode = 1;
    int qrdy_mode = 1;
    initial begin
        line_rdy = 1'b1;
        mem_req_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (lrdy_mode)
                0: line_rdy = 1'b0;
                2: line_rdy = !line_rdy;
                3: line_rdy = 1'($urandom_range(0, 1));
                default: line_rdy = 1'b1;
            endcase
            case (qrdy_mode)
                0: mem_req_rdy = 1'b0;
                2: mem_req_rdy = !mem_req_rdy;
                3: mem_req_rdy = 1'($urandom_range(0, 1));
                default: mem_req_rdy = 1'b1;
            endcase
        end
    end

    // Memory model: 0 hold, 1 in-order after 4 cycles, 2 random order, 3 order 3,1,0,2.
    int         resp_mode = 0;
    int         ord_ptr = 0;
    int         t0_cyc = -1;
    int         inj_cnt = 0;
    int         inj_done = 0;
    logic [5:0] inj_tid = 6'd0;
    initial begin
        int idx;
        int ord[4] = '{3, 1, 0, 2};
        mem_resp_val = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp_val = 1'b0;
            idx = -1;
            if (resp_mode != 3) ord_ptr = 0;
            if (inj_done != inj_cnt) begin
                mem_resp_val = 1'b1;
                mem_resp_transid = inj_tid;
                mem_resp_data = {16{$urandom}};
                inj_done++;
            end else if (resp_mode == 1 && pending.size() > 0) begin
                if (pending[0].cyc + 4 <= cyc) idx = 0;
            end else if (resp_mode == 2 && pending.size() > 0) begin
                if ($urandom_range(0, 2) != 0) idx = $urandom_range(0, pending.size() - 1);
            end else if (resp_mode == 3 && ord_ptr < 4 && pending.size() + ord_ptr == 4) begin
                for (int i = 0; i < pending.size(); i++)
                    if (int'(pending[i].tid) == TBS + ord[ord_ptr]) idx = i;
                if (ord[ord_ptr] == 0) t0_cyc = cyc;
                ord_ptr++;
            end
            if (idx >= 0) begin
                mem_resp_val = 1'b1;
                mem_resp_transid = pending[idx].tid;
                mem_resp_data = line_of(pending[idx].addr);
                pending.delete(idx);
            end
        end
    end

    // Request monitor: order/contents against the model and hold-while-stalled.
    logic          req_stall = 1'b0;
    logic [PW-1:0] stall_addr = '0;
    logic [5:0]    stall_tid = '0;
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_stall = 1'b0;
            end else begin
                if (req_stall) begin
                    chk("req_hold_val", 64'(mem_req_val), 64'(1));
                    chk("req_hold_addr", 64'(mem_req_addr), 64'(stall_addr));
                    chk("req_hold_tid", 64'(mem_req_transid), 64'(stall_tid));
                end
                if (mem_req_val && mem_req_rdy) begin
                    if (exp_req.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL req_unexpected: got addr %0h expected no request", mem_req_addr);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_addr", 64'(mem_req_addr), 64'(e.addr));
                        chk("req_tid", 64'(mem_req_transid), 64'(e.tid));
                    end
                    pending.push_back('{mem_req_transid, mem_req_addr, cyc});
                    nreq++;
                end
                req_stall  = mem_req_val && !mem_req_rdy;
                stall_addr = mem_req_addr;
                stall_tid  = mem_req_transid;
            end
        end
    end

    // Line monitor: in-order data/last, and FSM idle the cycle after the last pop.
    initial begin
        line_t e;
        logic  idle_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                idle_chk = 1'b0;
            end else begin
                if (idle_chk) begin
                    chk("busy_after_last", 64'(busy), 64'(0));
                    chk("cmd_rdy_after_last", 64'(cmd_rdy), 64'(1));
                    idle_chk = 1'b0;
                end
                if (line_val && line_rdy) begin
                    checks++;
                    if (exp_line.size() == 0) begin
                        failures++;
                        $display("FAIL line_unexpected: got line %0h expected no line", line_data[63:0]);
                    end else begin
                        e = exp_line.pop_front();
                        if (line_data !== e.data || line_last !== e.last) begin
                            failures++;
                            $display("FAIL line: got %0h last %0b expected %0h last %0b",
                                     line_data[63:0], line_last, e.data[63:0], e.last);
                        end
                        if (line_last) idle_chk = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_cmd(logic [PW-1:0] base, int n);
        logic [PW-1:0] ab, a;
        ab = base & ~PW'(63);
        for (int i = 0; i < n; i++) begin
            a = ab + PW'(i) * PW'(64);
            exp_req.push_back('{6'(TBS + i % NT), a});
            exp_line.push_back('{line_of(a), i == n - 1});
        end
        @(posedge clk); #1;
        chk("cmd_rdy_idle", 64'(cmd_rdy), 64'(1));
        cmd_val = 1'b1;
        cmd_base_addr = base;
        cmd_num_lines = LENW'(n);
        @(posedge clk); #1;
        cmd_val = 1'b0;
        if (n > 0) chk("first_req_val", 64'(mem_req_val), 64'(1));
    endtask

    task automatic wait_done(string name);
        int k = 0;
        do begin @(negedge clk); k++; end while ((busy || exp_line.size() != 0) && k < 3000);
        chk({name, "_done"}, 64'(busy || exp_line.size() != 0), 64'(0));
        chk({name, "_reqs_left"}, 64'(exp_req.size()), 64'(0));
    endtask

    task automatic chk_reset(string p);
        chk({p, "_cmd_rdy"}, 64'(cmd_rdy), 64'(1));
        chk({p, "_busy"}, 64'(busy), 64'(0));
        chk({p, "_req_val"}, 64'(mem_req_val), 64'(0));
        chk({p, "_req_addr"}, 64'(mem_req_addr), 64'(0));
        chk({p, "_req_tid"}, 64'(mem_req_transid), 64'(0));
        chk({p, "_line_val"}, 64'(line_val), 64'(0));
        chk({p, "_line_last"}, 64'(line_last), 64'(0));
        chk({p, "_line_data"}, 64'(line_data != '0), 64'(0));
        chk({p, "_err"}, 64'(err_stray), 64'(0));
    endtask

    task automatic pulse_rst(string p);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset(p);
        rst = 1'b0;
    endtask

    initial begin
        int n0, first, k;
        logic seen;
        rst = 1'b1;
        cmd_val = 1'b0;
        cmd_base_addr = '0;
        cmd_num_lines = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        // Basic in-order run.
        resp_mode = 1;
        run_cmd(40'h10_0000_40, 3);
        wait_done("t1");

        // Out-of-order responses; line 0 one cycle after its response.
        resp_mode = 3;
        run_cmd(40'h20_0000_00, 4);
        first = -1;
        k = 0;
        while (first < 0 && k < 200) begin
            @(negedge clk);
            if (line_val) first = cyc;
            k++;
        end
        chk("t2_line0_latency", 64'(first), 64'(t0_cyc + 1));
        wait_done("t2");

        // Consumer stalled: issue stops once every slot is reserved.
        resp_mode = 2;
        lrdy_mode = 0;
        n0 = nreq;
        run_cmd(PW'({$urandom, $urandom}), 20);
        repeat (50) @(negedge clk);
        chk("t3_issued", 64'(nreq - n0), 64'(NT));
        chk("t3_stall_val", 64'(mem_req_val), 64'(0));
        lrdy_mode = 1;
        wait_done("t3");

        // Toggling request ready and random consumer.
        qrdy_mode = 2;
        lrdy_mode = 3;
        run_cmd(PW'({$urandom, $urandom}), 13);
        wait_done("t4");
        qrdy_mode = 1;
        lrdy_mode = 1;

        // Address wrap at 2^PADDR_W.
        run_cmd(40'hFF_FFFF_FF80, 5);
        wait_done("t5");

        // Zero-length run.
        n0 = nreq;
        run_cmd(40'h30_0000_00, 0);
        chk("t6_cmd_rdy", 64'(cmd_rdy), 64'(1));
        chk("t6_busy", 64'(busy), 64'(0));
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen = seen | mem_req_val | line_val; end
        chk("t6_no_output", 64'(seen), 64'(0));
        chk("t6_no_req", 64'(nreq - n0), 64'(0));

        // Out-of-range transid mid-run.
        chk("t7_err_clear", 64'(err_stray), 64'(0));
        resp_mode = 0;
        run_cmd(40'h40_0000_00, 3);
        inj_tid = 6'd63;
        inj_cnt++;
        repeat (3) @(negedge clk);
        chk("t7_err_tid63", 64'(err_stray), 64'(1));
        resp_mode = 1;
        wait_done("t7a");
        pulse_rst("t7_rst");

        // Response to a FREE slot mid-run.
        resp_mode = 0;
        run_cmd(40'h50_0000_00, 3);
        inj_tid = 6'(TBS + 5);
        inj_cnt++;
        repeat (3) @(negedge clk);
        chk("t7_err_free", 64'(err_stray), 64'(1));
        resp_mode = 1;
        wait_done("t7b");
        pulse_rst("t8_pre");

        // Reset with 5 requests pending; late responses only raise err_stray.
        resp_mode = 0;
        n0 = nreq;
        run_cmd(40'h60_0000_00, 5);
        k = 0;
        while (nreq - n0 < 5 && k < 200) begin @(negedge clk); k++; end
        chk("t8_pending", 64'(nreq - n0), 64'(5));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("t8_rst");
        exp_req.delete();
        exp_line.delete();
        rst = 1'b0;
        resp_mode = 1;
        k = 0;
        while (pending.size() != 0 && k < 200) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        chk("t8_late_err", 64'(err_stray), 64'(1));
        chk("t8_busy", 64'(busy), 64'(0));
        pulse_rst("t8_clear");

        // Random runs.
        for (int r = 0; r < 4; r++) begin
            resp_mode = 2;
            qrdy_mode = 3;
            lrdy_mode = 3;
            run_cmd(PW'({$urandom, $urandom}), $urandom_range(1, 24));
            wait_done("rand");
        end
        chk("final_err", 64'(err_stray), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
